// File: rtl/mul_sequencer.sv
// mul_sequencer: iterative shift-add multiplier for the EX stage.
// Accepts MUL (6'b011100) instructions, stalls the pipeline while it steps
// through the multiplier bits, then presents the low WIDTH product bits for
// one cycle with a done pulse. Multiplier bits run LSB-first, so the engine
// stops as soon as no set bits remain.
module mul_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       opcode,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [5:0]    MUL_OP = 6'b011100;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mcand_next;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] mplier_next;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic [WIDTH-1:0] result_next;
    logic             busy_next;
    logic             done_next;

    logic             accept;
    logic [WIDTH-1:0] acc_step;
    logic             finish;

    // Accept decision, one shift-add step, and the early-exit test.
    always_comb begin
        accept   = (state == IDLE) && start && (opcode == MUL_OP) && !flush;
        acc_step = acc + (mplier[0] ? mcand : '0);
        finish   = ((mplier >> 1) == '0) || (count == LAST_STEP);
        stall    = accept || (state == RUN);
    end

    // Next-state and datapath updates; flush overrides every transition.
    always_comb begin
        state_next  = state;
        mcand_next  = mcand;
        mplier_next = mplier;
        acc_next    = acc;
        count_next  = count;
        result_next = result;
        busy_next   = 1'b0;
        done_next   = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    mcand_next  = op1;
                    mplier_next = op2;
                    acc_next    = '0;
                    count_next  = '0;
                    state_next  = RUN;
                    busy_next   = 1'b1;
                end
            end
            RUN: begin
                acc_next    = acc_step;
                mcand_next  = mcand << 1;
                mplier_next = mplier >> 1;
                count_next  = count + CW'(1);
                if (finish) begin
                    result_next = acc_step;
                    state_next  = DONE;
                    done_next   = 1'b1;
                end else begin
                    busy_next = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (flush) begin
            state_next  = IDLE;
            result_next = result;
            busy_next   = 1'b0;
            done_next   = 1'b0;
        end
    end

    // State and datapath registers, cleared immediately by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_next;
            mcand  <= mcand_next;
            mplier <= mplier_next;
            acc    <= acc_next;
            count  <= count_next;
            result <= result_next;
            busy   <= busy_next;
            done   <= done_next;
        end
    end

endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Iterative shift-add multiplier sequencer for the EX stage of the pipelined MIPS core. It replaces the single-cycle multiply path for the MUL opcode (6'b011100) with a multi-cycle engine. It holds the pipeline with a stall signal while it runs. It returns the low WIDTH bits of op1*op2 for the ALU result mux. All other ALU opcodes bypass this block.

## Interface
- WIDTH, 32, operand and result width in bits.

- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  EX-stage instruction valid this cycle.
- opcode  input  6  EX-stage primary opcode. Only 6'b011100 (MUL) is accepted.
- op1  input  WIDTH  multiplicand.
- op2  input  WIDTH  multiplier.
- flush  input  1  synchronous abort from branch/jump resolution.
- stall  output  1  hold IF/ID/EX pipeline registers (combinational).
- busy  output  1  registered; high while in RUN.
- done  output  1  registered; one-cycle pulse, result valid.
- result  output  WIDTH  product low WIDTH bits (registered).

## Operation
- States: IDLE, RUN, DONE.
- Internal registers:
  - mcand (WIDTH): shifts left each step; bits shifted out are discarded.
  - mplier (WIDTH): shifts right each step.
  - acc (WIDTH)
  - count (log2(WIDTH)+1 bits)
- IDLE:
  - If start && opcode==6'b011100 && !flush: load mcand=op1, mplier=op2, acc=0, count=0, and go to RUN.
  - Otherwise remain in IDLE.
- RUN, one step per cycle:
  - acc_next = acc + (mplier[0] ? mcand : 0), modulo 2^WIDTH.
  - mcand <<= 1; mplier >>= 1; count += 1.
  - If (mplier>>1)==0 or count==WIDTH-1: load result=acc_next and go to DONE.
  - Otherwise remain in RUN.
- DONE: done=1 for this single cycle, then go to IDLE unconditionally. start is ignored in DONE.
- start is ignored in RUN. Operands are not re-sampled after the load.
- Arithmetic is unsigned; the low WIDTH bits equal the signed low product.
- Early termination: a multiplier whose highest set bit is p takes p+1 RUN cycles. op2==0 takes exactly 1 RUN cycle and gives result 0.
- flush:
  - Takes priority over all transitions.
  - In RUN or DONE it forces IDLE on the next edge with done=0 in that cycle.
  - result keeps its previous value.
  - In IDLE with a valid start, the start is not accepted.
- result holds its last product until the next DONE load.
- stall = (state==IDLE && start && opcode==MUL && !flush) || state==RUN.
  - stall is 0 in DONE, so the pipeline advances while result is valid.

## Timing
- Reset values: state=IDLE, busy=0, done=0, result=0, acc=0, mcand=0, mplier=0, count=0, stall=0 (start low).
- Reset is asynchronous and may assert mid-RUN. All registers clear immediately and no done pulse is generated.
- Cycle accounting for an operation accepted at edge E0:
  - RUN occupies edges E1..Ek, where k = p+1, or 1 if op2==0, with k ≤ WIDTH.
  - DONE is entered at edge Ek; done=1 and result are valid from Ek to E(k+1).
- stall timing:
  - stall is high combinationally in the accept cycle and in every RUN cycle.
  - stall is low in the DONE cycle. The consumer samples result on the edge that leaves DONE.
- Minimum spacing between two MUL instructions: accept, k RUN cycles, DONE, IDLE. A new start is accepted no earlier than the first IDLE cycle after DONE.
- busy equals (state==RUN) and is registered.

## Test plan
- 3*5:
  - Stimulus: start=1, opcode=6'b011100, op1=3, op2=5.
  - Required: stall high for the accept cycle plus 3 RUN cycles; done pulses once; result=15; then IDLE.
- Zero multiplier:
  - Stimulus: op1=0x1234, op2=0.
  - Required: 1 RUN cycle, then done with result=0.
- Full-width operands:
  - Stimulus: op1=op2=0xFFFFFFFF.
  - Required: 32 RUN cycles; result=0x00000001; busy high exactly 32 cycles.
- Flush mid-run:
  - Stimulus: op1=7, op2=0x80000000; assert flush on RUN cycle 5.
  - Required: IDLE next edge, no done pulse, result unchanged from the prior product.
- Non-MUL opcode and ignored start:
  - Stimulus: start=1 with opcode=6'b001001.
  - Required: stall=0, state stays IDLE.
  - Stimulus: a second MUL start during RUN.
  - Required: ignored; the original operands finish correctly.
- Async reset mid-RUN:
  - Stimulus: 6*9 running; pulse reset between clock edges.
  - Required: busy, done, stall and result are 0 immediately.
  - Stimulus: a following 6*9 after reset.
  - Required: done with result=54.
